// File: rtl/prbs31_data_generator.sv
// PRBS31 (x^31 + x^28 + 1) word source, 32 bits per enabled clock, bit 0 earliest.
// Supports seed loading and single-bit error injection with a registered ack.
module prbs31_data_generator #(
   parameter logic [30:0] SEED = 31'h7FFFFFFF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        load_seed,
   input  logic [30:0] seed,
   input  logic        inject_req,
   input  logic [4:0]  inject_bit,
   output logic        inject_ack,
   output logic [31:0] DataOut,
   output logic        data_valid,
   output logic [63:0] Word_Count,
   output logic [31:0] Inject_Count
);

   typedef enum logic {IDLE, PENDING} inj_state_t;

   inj_state_t  state, state_nxt;
   logic [30:0] lfsr;
   logic [4:0]  inj_pos;
   logic [27:0] w_lo;
   logic [2:0]  w_mid;
   logic        w_top;
   logic [31:0] w;
   logic        emit;
   logic        inj_fire;
   logic        inj_capture;
   logic [31:0] flip_mask;

   // Bits 28..31 reuse bits of the word being built, so the chain is split
   // into stages that depend only on earlier stages.
   assign w_lo  = lfsr[27:0] ^ lfsr[30:3];
   assign w_mid = lfsr[30:28] ^ w_lo[2:0];
   assign w_top = w_lo[0] ^ w_lo[3];
   assign w     = {w_top, w_mid, w_lo};

   assign emit      = enable & ~load_seed;
   assign flip_mask = 32'd1 << inj_pos;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (inject_req) state_nxt = PENDING;
         PENDING: if (emit)       state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      inj_fire    = (state == PENDING) & emit;
      inj_capture = (state == IDLE) & inject_req;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr         <= SEED;
         inj_pos      <= 5'd0;
         DataOut      <= 32'd0;
         data_valid   <= 1'b0;
         inject_ack   <= 1'b0;
         Word_Count   <= 64'd0;
         Inject_Count <= 32'd0;
      end else begin
         data_valid <= emit;
         inject_ack <= inj_fire;
         if (inj_capture) inj_pos <= inject_bit;
         if (load_seed) begin
            lfsr <= (seed == 31'd0) ? SEED : seed;
         end else if (enable) begin
            // The flip goes only to the output; the state advances clean.
            lfsr       <= w[31:1];
            DataOut    <= w ^ (inj_fire ? flip_mask : 32'd0);
            Word_Count <= Word_Count + 64'd1;
            if (inj_fire) Inject_Count <= Inject_Count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_prbs31_data_generator.sv
// Directed bench for prbs31_data_generator: bit-serial golden model plus a
// self-synchronising receive checker that counts bit errors.
module tb_prbs31_data_generator;

   localparam logic [30:0] SEED = 31'h7FFFFFFF;

   logic        clock = 1'b0;
   logic        reset, enable, load_seed, inject_req;
   logic [30:0] seed;
   logic [4:0]  inject_bit;
   logic        inject_ack, data_valid;
   logic [31:0] DataOut, Inject_Count;
   logic [63:0] Word_Count;

   int          total = 0;
   int          bad = 0;
   int          rx_err = 0;
   longint      wc = 0;
   logic [30:0] gold, rxh;
   logic [31:0] last_w;

   prbs31_data_generator #(.SEED(SEED)) dut (
      .clock(clock), .reset(reset), .enable(enable), .load_seed(load_seed),
      .seed(seed), .inject_req(inject_req), .inject_bit(inject_bit),
      .inject_ack(inject_ack), .DataOut(DataOut), .data_valid(data_valid),
      .Word_Count(Word_Count), .Inject_Count(Inject_Count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Golden generator, one bit at a time: s[n] = s[n-31] ^ s[n-28].
   task automatic gen(output logic [31:0] wd);
      logic b;
      for (int k = 0; k < 32; k++) begin
         b = gold[0] ^ gold[3];
         wd[k] = b;
         gold = {b, gold[30:1]};
      end
   endtask

   // Receive checker: predicts each bit from the received history.
   task automatic rx();
      logic b;
      if (data_valid === 1'b1) begin
         for (int k = 0; k < 32; k++) begin
            b = DataOut[k];
            if (b !== (rxh[0] ^ rxh[3])) rx_err++;
            rxh = {b, rxh[30:1]};
         end
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      rx();
   endtask

   task automatic emit(input string tag, input logic [31:0] flip);
      logic [31:0] e;
      enable = 1'b1;
      cyc();
      gen(e);
      wc++;
      last_w = e ^ flip;
      check(tag, DataOut, e ^ flip);
   endtask

   initial begin
      reset = 1'b1; enable = 1'b0; load_seed = 1'b0; seed = 31'd0;
      inject_req = 1'b0; inject_bit = 5'd0;
      gold = SEED; rxh = SEED;
      cyc(); cyc();
      reset = 1'b0;
      check("rst_data", DataOut, 0);
      check("rst_valid", data_valid, 0);
      check("rst_ack", inject_ack, 0);
      check("rst_wc", Word_Count, 0);
      check("rst_ic", Inject_Count, 0);

      // First two words from the all-ones seed, hand derived.
      emit("word1", 0);
      check("word1_const", DataOut, 32'h70000000);
      check("word1_valid", data_valid, 1);
      check("word1_wc", Word_Count, 1);
      enable = 1'b0;
      cyc();
      check("idle_valid", data_valid, 0);
      check("idle_hold", DataOut, 32'h70000000);
      emit("word2", 0);
      check("word2_const", DataOut, 32'h3F000000);

      for (int i = 0; i < 300; i++) emit("run", 0);
      check("run_wc", Word_Count, wc);
      check("run_rx_err", rx_err, 0);

      // Request alongside an emitting cycle: applied on the following word.
      rx_err = 0;
      inject_req = 1'b1; inject_bit = 5'd5;
      emit("inj_same", 0);
      check("inj_same_ack", inject_ack, 0);
      inject_req = 1'b0;
      emit("inj_word", 32'd1 << 5);
      check("inj_ack", inject_ack, 1);
      check("inj_ic", Inject_Count, 1);
      emit("inj_after", 0);
      check("inj_after_ack", inject_ack, 0);
      for (int i = 0; i < 40; i++) emit("inj_tail", 0);
      check("inj_rx_err", rx_err, 3);

      // Second request while pending is ignored.
      enable = 1'b0;
      inject_req = 1'b1; inject_bit = 5'd9;
      cyc();
      check("pend_ack0", inject_ack, 0);
      check("pend_valid0", data_valid, 0);
      inject_bit = 5'd17;
      cyc(); cyc(); cyc();
      check("pend_ack3", inject_ack, 0);
      check("pend_wc", Word_Count, wc);
      inject_req = 1'b0;
      emit("pend_word", 32'd1 << 9);
      check("pend_ack", inject_ack, 1);
      check("pend_ic", Inject_Count, 2);

      // Load while pending keeps the request.
      enable = 1'b0;
      inject_req = 1'b1; inject_bit = 5'd2;
      cyc();
      inject_req = 1'b0;
      load_seed = 1'b1; seed = 31'h1234567; enable = 1'b1;
      cyc();
      check("ldp_valid", data_valid, 0);
      check("ldp_ack", inject_ack, 0);
      check("ldp_hold", DataOut, last_w);
      gold = 31'h1234567; rxh = 31'h1234567;
      load_seed = 1'b0;
      emit("ldp_word", 32'd1 << 2);
      check("ldp_ack1", inject_ack, 1);
      check("ldp_ic", Inject_Count, 3);

      // Zero seed with enable: SEED substituted, nothing emitted.
      load_seed = 1'b1; seed = 31'd0; enable = 1'b1;
      cyc();
      check("ld0_hold", DataOut, last_w);
      check("ld0_valid", data_valid, 0);
      check("ld0_wc", Word_Count, wc);
      gold = SEED; rxh = SEED;
      load_seed = 1'b0;
      emit("ld0_word", 0);
      check("ld0_const", DataOut, 32'h70000000);
      check("ld0_wc1", Word_Count, wc);

      // Reset while pending discards the request.
      enable = 1'b0;
      inject_req = 1'b1; inject_bit = 5'd3;
      cyc();
      inject_req = 1'b0;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      check("rp_data", DataOut, 0);
      check("rp_wc", Word_Count, 0);
      check("rp_ic", Inject_Count, 0);
      wc = 0; gold = SEED; rxh = SEED;
      emit("rp_word", 0);
      check("rp_const", DataOut, 32'h70000000);
      check("rp_ack", inject_ack, 0);
      emit("rp_word2", 0);
      check("rp_ack2", inject_ack, 0);
      check("rp_ic2", Inject_Count, 0);
      check("rp_wc2", Word_Count, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/prbs31_data_generator.md
# prbs31_data_generator

Transmit-side PRBS31 source for the GBCR2 SEU test: each enabled clock it produces one 32-bit word of the X[n] = X[n-31] ^ X[n-28] sequence. It sits in front of the serializer feeding the GBCR2 channel under test, and its bit ordering is exactly what the receive-side PRBS31 checker expects. It supports seed loading, single-bit error injection with a request/acknowledge handshake, and word and injection counters for run bookkeeping.

## Interface
- SEED, 31'h7FFFFFFF: LFSR state after reset, and the substitute for an all-zero seed.
- clock  in  1  word clock, same domain as the checker.
- reset  in  1  synchronous, active-high.
- enable  in  1  advance the sequence by one word this cycle.
- load_seed  in  1  load `seed` into the LFSR this cycle.
- seed  in  31  seed value; seed[j] is stream bit s[j-31], so seed[30] is the newest bit.
- inject_req  in  1  request a single-bit error on the next emitted word.
- inject_bit  in  5  bit position to flip, captured with inject_req.
- inject_ack  out  1  one-cycle pulse; the corrupted word is on DataOut in this cycle.
- DataOut  out  32  PRBS word; bit 0 is the earliest bit in time, bit 31 the latest.
- data_valid  out  1  DataOut was updated this cycle.
- Word_Count  out  64  number of words emitted since reset.
- Inject_Count  out  32  number of errors injected since reset.

## Operation
- LFSR state: 31 bits, lfsr[j] = s[n-31+j].
  - Next word, for k=0..31: w[k] = s[k-31] ^ s[k-28].
  - Bits k≥31 and k≥28 use bits w[] computed earlier in the same word, so the 32 bits form a combinational chain.
  - New state = w[31:1].
- Priority each cycle: reset > load_seed > enable.
- load_seed:
  - lfsr <= (seed==0) ? SEED : seed.
  - DataOut holds, data_valid = 0, and Word_Count does not increment, even if enable is high.
- enable with no load:
  - DataOut <= w ^ (pending ? (1<<inj_pos) : 0).
  - data_valid <= 1 and Word_Count += 1.
  - The LFSR always advances with the uncorrupted w; the injected flip is never fed back into the state.
- enable low: DataOut, lfsr and counters hold; data_valid <= 0.
- Injection state machine, states IDLE and PENDING:
  - IDLE, inject_req=1: capture inject_bit into inj_pos and go to PENDING.
  - PENDING, on the first cycle that emits a word (enable=1, load_seed=0): apply the flip, assert inject_ack, Inject_Count += 1, return to IDLE.
  - inject_req while PENDING: ignored; no ack, inj_pos is unchanged.
  - inject_req in IDLE in the same cycle as an emitting enable: goes to PENDING only. The flip lands on the following emitted word; a request is never applied in its own cycle.
  - load_seed while PENDING: the request stays pending.
- Counters: 64-bit and 32-bit binary, wrap modulo 2^width with no saturation.
- All-zero LFSR state is unreachable: reset loads SEED, and a zero seed is replaced by SEED.

## Timing
- Reset values: lfsr=SEED; DataOut=0; data_valid=0; inject_ack=0; Word_Count=0; Inject_Count=0; state IDLE.
- All outputs are registered.
- enable in cycle t: the word appears on DataOut with data_valid=1 at t+1.
- inject_req at t: the earliest corrupted word, with its inject_ack, appears at t+2, given enable is high at t+1.
- Reset asserted mid-operation: all state clears in one cycle and any pending injection is discarded.
- Downstream checker behaviour: one injected flip produces exactly 3 counted bit errors there (the flipped bit, plus its use as the n-28 and n-31 tap), provided at least 31 further bits follow.

## Test plan
- Reset, then enable for one cycle with SEED=all-ones -> DataOut=32'h70000000, data_valid=1, Word_Count=1.
- Continuous enable for 10,000 words into the receive checker -> Error_bit_Count stays 0; Word_Count=10000.
- inject_req with inject_bit=5 during steady enable -> inject_ack exactly 2 cycles later; that word differs from the golden model only in bit 5; checker Error_bit_Count=3; Inject_Count=1.
- Second inject_req while PENDING, with enable held low for 4 cycles -> no word emitted and no ack; when enable rises, a single ack and one flip at the first captured position.
- load_seed with seed=0 asserted together with enable -> lfsr=SEED, DataOut holds, data_valid=0, Word_Count unchanged; the next enabled word is 32'h70000000.
- Reset asserted while PENDING, then enable -> no ack and no corruption; Inject_Count=0; DataOut=32'h70000000.
